seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider, the inverse-arithmetic companion to the ripple adder.
- Produces quotient and remainder one bit per clock.
- Each trial subtraction uses a single (WIDTH+1)-bit adder instance in subtract mode.
- Serves game logic that needs div/mod, e.g. score-to-digit conversion and column index from a linear cell index, without a combinational divider.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when not busy
dividend  input  WIDTH  unsigned numerator, captured on accepted start
divisor  input  WIDTH  unsigned denominator, captured on accepted start
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Reset (reset_n low at a rising edge): state IDLE; busy, done, quotient, remainder and div_by_zero all 0; internal registers cleared.
- Reset wins over every other input. Reset mid-RUN aborts the operation and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE/DONE to RUN: start=1 and divisor!=0.
  - Capture the dividend into the shift register and the divisor into the divisor register.
  - Clear the partial remainder (WIDTH+1 bits) and load the bit counter with WIDTH-1.
- IDLE/DONE to DONE (divide by zero): start=1 and divisor==0.
  - Next cycle: done=1, quotient = all ones, remainder = dividend, div_by_zero=1.
  - Latency is 1 cycle.
- RUN step, once per cycle:
  - shifted = {partial[WIDTH-1:0], dvd_reg[WIDTH-1]}; shift dvd_reg left by 1.
  - trial = shifted + ~{1'b0, divisor} + 1, computed by the adder instance (cin=1).
  - trial[WIDTH]==0: partial = trial, quotient bit = 1. Otherwise partial = shifted, quotient bit = 0.
  - Quotient bits shift into the LSB of dvd_reg, so dvd_reg holds the quotient after WIDTH steps.
  - Width rule: trial always fits in WIDTH+1 signed bits. The adder overflow output is unused.
- RUN to DONE: after the step where the counter is 0.
  - quotient and remainder output registers load from dvd_reg and partial[WIDTH-1:0]; div_by_zero=0.
  - done=1 for exactly the DONE cycle.
- Latency: start sampled at edge 0; busy=1 during cycles 1..WIDTH; done=1 in cycle WIDTH+1.
- busy=0 in IDLE and DONE.
- DONE with start=0 goes to IDLE next cycle; done drops to 0.
- Outputs hold their last completed result until the next completion or reset. They do not change during RUN.
- start while busy is ignored: no capture, no queueing, no effect on the in-flight result.
- Back-to-back: start asserted in the DONE cycle is accepted. No idle bubble is required.
- Operand inputs are don't-care except in the cycle start is accepted.

Decomposition:
- Shared package divider_pkg: typedef enum logic [1:0] div_state_t {IDLE, RUN, DONE}.
- One sub-module: an instance of the existing adder with WIDTH+1 in subtract configuration (b inverted, cin=1). No other submodules.
- Counter width: $clog2(WIDTH).

Test Plan:
- WIDTH=8, reset then start with 100/7 -> busy cycles 1..8, done in cycle 9, quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0; then 5/9 -> quotient=0, remainder=5; then 255/255 -> quotient=1, remainder=0.
- 200/0 -> done in cycle 1 after start, quotient=255, remainder=200, div_by_zero=1, busy never high.
- 100/7 in flight, start pulsed at cycle 4 with 50/5 -> ignored, completion still reports 14/2; outputs hold previous values during RUN.
- Start 100/7, reset_n low in cycle 5 -> next cycle all outputs 0, state IDLE, no done pulse.
- Start asserted in done cycle with 63/8 -> accepted, second done 9 cycles later with quotient=7, remainder=7.
- Random sweep with scoreboard against / and %.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types for the sequential divider.
package divider_pkg;

  // Controller states: waiting, shifting one bit per clock, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_adder.sv
// Ripple-carry adder used by the divider for its trial subtraction.
// The caller supplies the inverted subtrahend and cin=1. The trial
// difference always fits in the operand width, so no carry-out or
// overflow output is needed.
module seq_divider_adder #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  // Bit-serial carry chain, LSB first.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// A zero divisor short-circuits to an all-ones quotient with the dividend
// as remainder and raises div_by_zero one cycle later.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_t       state;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dsr_reg;
  // The restored partial remainder is always below the divisor, so the
  // extra top bit of the (WIDTH+1)-bit partial is always zero and is not kept.
  logic [WIDTH-1:0] partial;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] next_dvd;
  logic [WIDTH-1:0] next_partial;

  // Trial subtraction: shifted - divisor, done as shifted + ~divisor + 1.
  seq_divider_adder #(.W(WIDTH + 1)) u_sub (
    .a   (shifted),
    .b   (~{1'b0, dsr_reg}),
    .cin (1'b1),
    .sum (trial)
  );

  // One restoring step: keep the difference when it is non-negative.
  always_comb begin
    shifted      = {partial, dvd_reg[WIDTH-1]};
    next_dvd     = {dvd_reg[WIDTH-2:0], ~trial[WIDTH]};
    next_partial = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_reg     <= '0;
      dsr_reg     <= '0;
      partial     <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              state   <= RUN;
              busy    <= 1'b1;
              dvd_reg <= dividend;
              dsr_reg <= divisor;
              partial <= '0;
              count   <= CW'(WIDTH - 1);
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dvd_reg <= next_dvd;
          partial <= next_partial;
          if (count == '0) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= next_dvd;
            remainder   <= next_partial;
            div_by_zero <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results come from plain
// integer / and %, queued at issue and compared whenever done pulses.
module tb_seq_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  exp_t         sb[$];
  logic [W-1:0] prevQ = '0;
  logic [W-1:0] prevR = '0;
  logic         prevZ = 1'b0;
  int           total = 0;
  int           bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest queued result.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", 32'(quotient), 32'(e.q));
        checkOutput("remainder", 32'(remainder), 32'(e.r));
        checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.z));
        prevQ = e.q;
        prevR = e.r;
        prevZ = e.z;
      end
    end
  end

  // Issue one division at the current negedge and follow it to its done
  // cycle. pulseAt>0 fires an extra start (50/5) in that busy cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input int pulseAt);
    exp_t e;
    int   lat = 0;
    bit   busyOk = 1'b1;
    bit   holdOk = 1'b1;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = W'(int'(a) / int'(b));
      e.r = W'(int'(a) % int'(b));
      e.z = 1'b0;
    end
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == pulseAt + 1) start = 1'b0;
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      if (busy !== 1'b1) busyOk = 1'b0;
      if (quotient !== prevQ || remainder !== prevR || div_by_zero !== prevZ)
        holdOk = 1'b0;
      if (cyc == pulseAt) begin
        start    = 1'b1;
        dividend = W'(50);
        divisor  = W'(5);
      end
      @(negedge clk);
    end
    checkOutput("latency", 32'(lat), (b == 0) ? 32'd1 : 32'(W + 1));
    checkOutput("busy_in_run", 32'(busyOk), 32'd1);
    checkOutput("hold_in_run", 32'(holdOk), 32'd1);
    checkOutput("busy_in_done", 32'(busy), 32'd0);
  endtask

  // Let the DONE cycle pass with start low and check the pulse ended.
  task automatic idleCycle();
    @(negedge clk);
    checkOutput("done_drop", 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           noDone;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_q", 32'(quotient), 32'd0);
    checkOutput("reset_r", 32'(remainder), 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'd100, 8'd7, 0);
    idleCycle();
    applyStimulus(8'd255, 8'd1, 0);
    idleCycle();
    applyStimulus(8'd5, 8'd9, 0);
    idleCycle();
    applyStimulus(8'd255, 8'd255, 0);
    idleCycle();
    applyStimulus(8'd200, 8'd0, 0);
    idleCycle();

    // Start while busy must be ignored.
    applyStimulus(8'd100, 8'd7, 4);
    idleCycle();

    // Reset in the middle of a division aborts it silently.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    prevQ = '0;
    prevR = '0;
    prevZ = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_q", 32'(quotient), 32'd0);
    checkOutput("midreset_r", 32'(remainder), 32'd0);
    checkOutput("midreset_dbz", 32'(div_by_zero), 32'd0);
    reset_n = 1'b1;
    noDone  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) noDone = 1'b0;
    end
    checkOutput("no_done_after_reset", 32'(noDone), 32'd1);

    // Back-to-back: second start issued in the first result's done cycle.
    applyStimulus(8'd100, 8'd7, 0);
    applyStimulus(8'd63, 8'd8, 0);
    idleCycle();

    // Random sweep, sometimes back-to-back, sometimes with a zero divisor.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      applyStimulus(ra, rb, 0);
      if ($urandom_range(0, 1) == 0) idleCycle();
    end
    idleCycle();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
